jtdd2_mcu_bridge: RTL and testbench

JTDD2_MCU_BRIDGE -- requirements
Module: jtdd2_mcu_bridge

---
 rtl/jtdd2_mcu_bridge_if.sv | 21 ++
 rtl/jtdd2_mcu_bridge.sv | 82 ++++++++
 tb/tb_jtdd2_mcu_bridge.sv | 112 +++++++++++
 3 files changed

// File: rtl/jtdd2_mcu_bridge_if.sv
// jtdd2_mcu_bridge_if: main CPU side bus of the MCU bridge (decoded strobes, write data, status/wait/irq).
interface jtdd2_mcu_bridge_if;
  logic       main_cen;
  logic       ctrl_cs;
  logic       nmi_cs;
  logic       irqack_cs;
  logic       shr_cs;
  logic       main_wrn;
  logic [7:0] main_dout;
  logic [7:0] status;
  logic       main_wait;
  logic       main_irq;
  modport master (
    output main_cen, ctrl_cs, nmi_cs, irqack_cs, shr_cs, main_wrn, main_dout,
    input  status, main_wait, main_irq
  );
  modport slave (
    input  main_cen, ctrl_cs, nmi_cs, irqack_cs, shr_cs, main_wrn, main_dout,
    output status, main_wait, main_irq
  );
endinterface

// File: rtl/jtdd2_mcu_bridge.sv
// jtdd2_mcu_bridge: main CPU <-> MCU control, bus-request handshake, NMI pulse and IRQ latch.
// Optional REQ timeout enabled by defining JTDD2_MCU_TIMEOUT_EN.
module jtdd2_mcu_bridge (
  input  logic clk,
  input  logic rst,
  jtdd2_mcu_bridge_if.slave bus,
  output logic mcu_rstb,
  output logic mcu_halt,
  output logic mcu_nmi_set,
  output logic com_cs,
  input  logic mcu_ban,
  input  logic mcu_irqmain
);
  typedef enum logic [1:0] {RUN, REQ, HALTED, REL} state_t;
  state_t     state;
  logic       mcu_run, halt_req, irq_last, main_irq, timeout, wr, unused_dout;
  logic [1:0] nmi_cnt;
`ifdef JTDD2_MCU_TIMEOUT_EN
  logic [7:0] cnt;
`else
  assign timeout = 1'b0;
`endif
  assign wr            = bus.main_cen & ~bus.main_wrn;
  assign unused_dout   = ^bus.main_dout[7:2];
  assign bus.status    = {5'd0, timeout, state == HALTED, mcu_run};
  assign bus.main_wait = bus.shr_cs & (state != HALTED) & mcu_run;
  assign bus.main_irq  = main_irq;
  assign com_cs        = bus.shr_cs & (state == HALTED);
  assign mcu_nmi_set   = nmi_cnt != 2'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      mcu_run  <= 1'b0;
      halt_req <= 1'b0;
      state    <= RUN;
      mcu_rstb <= 1'b0;
      mcu_halt <= 1'b0;
      nmi_cnt  <= 2'd0;
      irq_last <= 1'b0;
      main_irq <= 1'b0;
`ifdef JTDD2_MCU_TIMEOUT_EN
      timeout  <= 1'b0;
      cnt      <= 8'd0;
`endif
    end else begin
      mcu_rstb <= mcu_run;
      irq_last <= mcu_irqmain;
      // a fresh edge wins over a simultaneous acknowledge
      main_irq <= (mcu_irqmain & ~irq_last) | (main_irq & ~(bus.irqack_cs & wr));
      nmi_cnt  <= bus.nmi_cs & wr ? 2'd2 : nmi_cnt - {1'b0, |nmi_cnt};
`ifdef JTDD2_MCU_TIMEOUT_EN
      cnt <= state == REQ && mcu_run && mcu_ban ? cnt + {7'd0, bus.main_cen} : 8'd0;
`endif
      if (!mcu_run) begin
        state    <= RUN;
        mcu_halt <= 1'b0;
      end else
        case (state)
          RUN:    if (halt_req) begin state <= REQ; mcu_halt <= 1'b1; end
          REQ:
            if (!mcu_ban) state <= HALTED;
`ifdef JTDD2_MCU_TIMEOUT_EN
            else if (bus.main_cen && cnt == 8'd254) begin
              state    <= RUN;
              mcu_halt <= 1'b0;
              timeout  <= 1'b1;
              halt_req <= 1'b0;
              cnt      <= 8'd0;
            end
`endif
          HALTED: if (!halt_req) begin state <= REL; mcu_halt <= 1'b0; end
          REL:    if (mcu_ban) begin state <= halt_req ? REQ : RUN; mcu_halt <= halt_req; end
        endcase
      if (bus.ctrl_cs & wr) begin
        mcu_run  <= bus.main_dout[0];
        halt_req <= bus.main_dout[1];
`ifdef JTDD2_MCU_TIMEOUT_EN
        timeout  <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_jtdd2_mcu_bridge.sv
// tb_jtdd2_mcu_bridge: vector table plus hand sequences checked through an expectation queue.
module tb_jtdd2_mcu_bridge;
  typedef enum {NOP, CTRL, NMI, ACK, ACKR, CTRL_NOCEN, RST} op_e;
  typedef struct {
    string       name;
    op_e         op;
    logic [7:0]  dout;
    logic        shr, ban, irqm;
    logic [13:0] exp;
  } vec_t;
  typedef struct {
    string       name;
    logic [13:0] exp;
  } sb_t;
  logic clk = 1'b0, rst, mcu_rstb, mcu_halt, mcu_nmi_set, com_cs, mcu_ban, mcu_irqmain;
  int n_cmp = 0, n_bad = 0;
  vec_t tbl[$];
  sb_t  sb[$];
  jtdd2_mcu_bridge_if bus ();
  jtdd2_mcu_bridge dut (
    .clk(clk), .rst(rst), .bus(bus), .mcu_rstb(mcu_rstb), .mcu_halt(mcu_halt),
    .mcu_nmi_set(mcu_nmi_set), .com_cs(com_cs), .mcu_ban(mcu_ban), .mcu_irqmain(mcu_irqmain)
  );
  always #5 clk = ~clk;
  // flags: {mcu_rstb, mcu_halt, mcu_nmi_set, main_irq, main_wait, com_cs}
  function automatic logic [13:0] o(logic [7:0] st, logic [5:0] f);
    return {st, f};
  endfunction
  function automatic vec_t v(string n, op_e op, logic [7:0] d, logic s, logic b, logic i, logic [13:0] e);
    vec_t r;
    r.name = n; r.op = op; r.dout = d; r.shr = s; r.ban = b; r.irqm = i; r.exp = e;
    return r;
  endfunction
  task automatic apply(vec_t x);
    sb_t  s;
    logic [13:0] got;
    rst           = x.op == RST;
    bus.main_cen  = x.op != CTRL_NOCEN;
    bus.ctrl_cs   = x.op inside {CTRL, CTRL_NOCEN};
    bus.nmi_cs    = x.op == NMI;
    bus.irqack_cs = x.op inside {ACK, ACKR};
    bus.main_wrn  = !(x.op inside {CTRL, CTRL_NOCEN, NMI, ACK});
    bus.main_dout = x.dout;
    bus.shr_cs    = x.shr;
    mcu_ban       = x.ban;
    mcu_irqmain   = x.irqm;
    sb.push_back('{x.name, x.exp});
    @(posedge clk);
    #1;
    s   = sb.pop_front();
    got = {bus.status, mcu_rstb, mcu_halt, mcu_nmi_set, bus.main_irq, bus.main_wait, com_cs};
    n_cmp++;
    if (got !== s.exp) begin
      n_bad++;
      $display("FAIL %s: got status=%h flags=%b, want status=%h flags=%b",
               s.name, got[13:6], got[5:0], s.exp[13:6], s.exp[5:0]);
    end
  endtask
  initial begin
    tbl.push_back(v("reset",      RST,  8'h00, 0, 1, 0, o(8'h00, 6'b000000)));
    tbl.push_back(v("idle",       NOP,  8'h00, 0, 1, 0, o(8'h00, 6'b000000)));
    tbl.push_back(v("ctrl01",     CTRL, 8'h01, 0, 1, 0, o(8'h01, 6'b000000)));
    tbl.push_back(v("rstb_on",    NOP,  8'h00, 0, 1, 0, o(8'h01, 6'b100000)));
    tbl.push_back(v("run_shr",    NOP,  8'h00, 1, 1, 0, o(8'h01, 6'b100010)));
    tbl.push_back(v("ctrl03",     CTRL, 8'h03, 0, 1, 0, o(8'h01, 6'b100000)));
    tbl.push_back(v("req",        NOP,  8'h00, 0, 1, 0, o(8'h01, 6'b110000)));
    tbl.push_back(v("req_shr",    NOP,  8'h00, 1, 1, 0, o(8'h01, 6'b110010)));
    tbl.push_back(v("halted_shr", NOP,  8'h00, 1, 0, 0, o(8'h03, 6'b110001)));
    tbl.push_back(v("halted",     NOP,  8'h00, 0, 0, 0, o(8'h03, 6'b110000)));
    tbl.push_back(v("ctrl01_hlt", CTRL, 8'h01, 0, 0, 0, o(8'h03, 6'b110000)));
    tbl.push_back(v("rel",        NOP,  8'h00, 0, 0, 0, o(8'h01, 6'b100000)));
    tbl.push_back(v("rel_shr",    NOP,  8'h00, 1, 0, 0, o(8'h01, 6'b100010)));
    tbl.push_back(v("ctrl03_rel", CTRL, 8'h03, 0, 0, 0, o(8'h01, 6'b100000)));
    tbl.push_back(v("rel2req",    NOP,  8'h00, 0, 1, 0, o(8'h01, 6'b110000)));
    tbl.push_back(v("ctrl00",     CTRL, 8'h00, 0, 1, 0, o(8'h00, 6'b110000)));
    tbl.push_back(v("forced_run", NOP,  8'h00, 1, 1, 0, o(8'h00, 6'b000000)));
    tbl.push_back(v("nmi_w",      NMI,  8'h00, 0, 1, 0, o(8'h00, 6'b001000)));
    tbl.push_back(v("nmi_2",      NOP,  8'h00, 0, 1, 0, o(8'h00, 6'b001000)));
    tbl.push_back(v("nmi_off",    NOP,  8'h00, 0, 1, 0, o(8'h00, 6'b000000)));
    tbl.push_back(v("irq_rise",   NOP,  8'h00, 0, 1, 1, o(8'h00, 6'b000100)));
    tbl.push_back(v("irq_hold",   NOP,  8'h00, 0, 1, 1, o(8'h00, 6'b000100)));
    tbl.push_back(v("irq_ack",    ACK,  8'h00, 0, 1, 1, o(8'h00, 6'b000000)));
    tbl.push_back(v("irq_fall",   NOP,  8'h00, 0, 1, 0, o(8'h00, 6'b000000)));
    tbl.push_back(v("irq_setclr", ACK,  8'h00, 0, 1, 1, o(8'h00, 6'b000100)));
    tbl.push_back(v("ack_rd",     ACKR, 8'h00, 0, 1, 1, o(8'h00, 6'b000100)));
    tbl.push_back(v("ack2",       ACK,  8'h00, 0, 1, 1, o(8'h00, 6'b000000)));
    tbl.push_back(v("cen0_ctrl",  CTRL_NOCEN, 8'h01, 0, 1, 1, o(8'h00, 6'b000000)));
    foreach (tbl[i]) apply(tbl[i]);
    apply(v("seqa_ctrl03", CTRL, 8'h03, 0, 1, 0, o(8'h01, 6'b000000)));
    for (int i = 0; i < 10; i++) apply(v("seqa_req", NOP, 8'h00, 0, 1, 0, o(8'h01, 6'b110000)));
    apply(v("seqa_halted", NOP, 8'h00, 0, 0, 0, o(8'h03, 6'b110000)));
    apply(v("seqb_nmi1",   NMI, 8'h00, 0, 0, 0, o(8'h03, 6'b111000)));
    apply(v("seqb_nmi2",   NMI, 8'h00, 0, 0, 0, o(8'h03, 6'b111000)));
    apply(v("seqb_nmi3",   NOP, 8'h00, 0, 0, 0, o(8'h03, 6'b111000)));
    apply(v("seqb_nmi_off", NOP, 8'h00, 0, 0, 0, o(8'h03, 6'b110000)));
    apply(v("seqc_irq",    NOP, 8'h00, 0, 0, 1, o(8'h03, 6'b110100)));
    apply(v("seqc_nmi",    NMI, 8'h00, 0, 0, 1, o(8'h03, 6'b111100)));
    apply(v("seqc_rst",    RST, 8'h00, 0, 0, 1, o(8'h00, 6'b000000)));
    apply(v("seqc_edge",   NOP, 8'h00, 0, 0, 1, o(8'h00, 6'b000100)));
    apply(v("seqd_ctrl03", CTRL, 8'h03, 0, 1, 1, o(8'h01, 6'b000100)));
    apply(v("seqd_req",    NOP, 8'h00, 0, 1, 1, o(8'h01, 6'b110100)));
`ifdef JTDD2_MCU_TIMEOUT_EN
    for (int i = 0; i < 254; i++) apply(v("seqd_wait", NOP, 8'h00, 0, 1, 1, o(8'h01, 6'b110100)));
    apply(v("seqd_timeout", NOP, 8'h00, 0, 1, 1, o(8'h05, 6'b100100)));
    apply(v("seqd_tclr", CTRL, 8'h01, 0, 1, 1, o(8'h01, 6'b100100)));
`else
    for (int i = 0; i < 300; i++) apply(v("seqd_wait", NOP, 8'h00, 0, 1, 1, o(8'h01, 6'b110100)));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
